// File: rtl/ppu_pkg.sv
// Shared PPU definitions: line geometry, pixel format helpers and the mixer state encoding.
// Used by pixel_mixer; optional sprite-behind priority is enabled with PIXEL_MIXER_PRIO_EN.
package ppu_pkg;

    localparam int LINE_PIXELS = 320;
    localparam int PIX_W       = 8;

    localparam logic [PIX_W-1:0] PIX_BACKDROP = 8'h00;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        MIX   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } mixer_state_t;

    // Colour index 0 in the low nibble marks a transparent pixel; the palette nibble is ignored.
    function automatic logic is_opaque(input logic [PIX_W-1:0] pix);
        return (pix & 8'h0F) != 8'h00;
    endfunction

endpackage

// File: rtl/pixel_mixer_select.sv
// Combinational three-layer priority select: SPR > FG > BG > backdrop.
// With PIXEL_MIXER_PRIO_EN defined, spr_behind lets an opaque FG pixel cover the sprite.
module pixel_mixer_select
    import ppu_pkg::*;
#(
    parameter int PIX_W = ppu_pkg::PIX_W
) (
    input  logic [PIX_W-1:0] bg_pix,
    input  logic [PIX_W-1:0] fg_pix,
    input  logic [PIX_W-1:0] spr_pix,
`ifdef PIXEL_MIXER_PRIO_EN
    input  logic             spr_behind,
`endif
    output logic [PIX_W-1:0] mix_pix
);

    logic spr_wins;

    always_comb begin
        mix_pix  = PIX_BACKDROP;
        spr_wins = is_opaque(spr_pix);
`ifdef PIXEL_MIXER_PRIO_EN
        if (spr_behind && is_opaque(fg_pix)) begin
            spr_wins = 1'b0;
        end
`endif
        if (spr_wins) begin
            mix_pix = spr_pix;
        end else if (is_opaque(fg_pix)) begin
            mix_pix = fg_pix;
        end else if (is_opaque(bg_pix)) begin
            mix_pix = bg_pix;
        end
    end

endmodule

// File: rtl/pixel_mixer.sv
// Scanline mixer: walks the engine line buffers, selects the top opaque pixel and writes the scanline buffer.
// Optional sprite-behind priority input is present only when PIXEL_MIXER_PRIO_EN is defined.
module pixel_mixer
    import ppu_pkg::*;
#(
    parameter int LINE_PIXELS = ppu_pkg::LINE_PIXELS,
    parameter int PIX_W       = ppu_pkg::PIX_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             swap,
    input  logic             bg_done,
    input  logic             fg_done,
    input  logic             spr_done,
    output logic [8:0]       pixel_addr,
    input  logic [PIX_W-1:0] bg_data,
    input  logic [PIX_W-1:0] fg_data,
    input  logic [PIX_W-1:0] spr_data,
`ifdef PIXEL_MIXER_PRIO_EN
    input  logic             spr_behind,
`endif
    output logic [8:0]       lb_addr,
    output logic [PIX_W-1:0] lb_data,
    output logic             lb_wren,
    output logic             done
);

    localparam logic [8:0] LAST_ADDR = 9'(LINE_PIXELS - 1);

    mixer_state_t     state;
    logic [8:0]       cnt;
    logic             drain_cnt;
    logic             all_done;
    logic             all_done_q;
    logic             arm;
    logic [8:0]       addr_d1;
    logic             valid_d1;
    logic [PIX_W-1:0] mixed;

    assign all_done   = bg_done & fg_done & spr_done;
    // Only a fresh rise of all_done starts a line, so a level still high after a swap is ignored.
    assign arm        = all_done & ~all_done_q;
    assign pixel_addr = cnt;

    pixel_mixer_select #(
        .PIX_W (PIX_W)
    ) u_select (
        .bg_pix     (bg_data),
        .fg_pix     (fg_data),
        .spr_pix    (spr_data),
`ifdef PIXEL_MIXER_PRIO_EN
        .spr_behind (spr_behind),
`endif
        .mix_pix    (mixed)
    );

    // Address is delayed twice (read latency + write register); a swap kills any in-flight pixel.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            cnt        <= '0;
            drain_cnt  <= 1'b0;
            all_done_q <= 1'b0;
            addr_d1    <= '0;
            valid_d1   <= 1'b0;
            lb_addr    <= '0;
            lb_data    <= '0;
            lb_wren    <= 1'b0;
            done       <= 1'b0;
        end else begin
            all_done_q <= all_done;
            valid_d1   <= 1'b0;
            lb_wren    <= 1'b0;

            unique case (state)
                IDLE: begin
                    if (arm && !swap) begin
                        state <= MIX;
                        cnt   <= '0;
                    end
                end
                MIX: begin
                    if (swap) begin
                        state <= IDLE;
                    end else begin
                        valid_d1 <= 1'b1;
                        addr_d1  <= cnt;
                        if (cnt == LAST_ADDR) begin
                            state     <= DRAIN;
                            drain_cnt <= 1'b0;
                        end else begin
                            cnt <= cnt + 9'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (swap) begin
                        state <= IDLE;
                    end else if (drain_cnt) begin
                        state <= DONE;
                        done  <= 1'b1;
                    end else begin
                        drain_cnt <= 1'b1;
                    end
                end
                DONE: begin
                    if (swap) begin
                        state <= IDLE;
                        done  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
            endcase

            if (valid_d1 && !swap) begin
                lb_wren <= 1'b1;
                lb_addr <= addr_d1;
                lb_data <= mixed;
            end
        end
    end

endmodule

// File: tb/tb_pixel_mixer.sv
// Scoreboard bench for pixel_mixer: random line buffers, reference priority model, timing and abort checks.
// Define PIXEL_MIXER_PRIO_EN for both RTL and bench to exercise the spr_behind input.
module tb_pixel_mixer;

    localparam int N = 320;

    typedef struct {
        int         addr;
        logic [7:0] pix;
    } wr_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       swap;
    logic       bg_done, fg_done, spr_done;
    logic [8:0] pixel_addr;
    logic [7:0] bg_data, fg_data, spr_data;
    logic [8:0] lb_addr;
    logic [7:0] lb_data;
    logic       lb_wren;
    logic       done;
`ifdef PIXEL_MIXER_PRIO_EN
    logic       spr_behind;
`endif

    logic [7:0] bg_mem [N];
    logic [7:0] fg_mem [N];
    logic [7:0] spr_mem[N];
    logic       beh_mem[N];
    logic [7:0] lb_mem [N];

    wr_t exp_q[$];
    int  checks = 0;
    int  passes = 0;
    int  cyc = 0;
    int  write_cnt = 0;
    int  first_w = -1;
    int  last_w = -1;

    pixel_mixer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .swap       (swap),
        .bg_done    (bg_done),
        .fg_done    (fg_done),
        .spr_done   (spr_done),
        .pixel_addr (pixel_addr),
        .bg_data    (bg_data),
        .fg_data    (fg_data),
        .spr_data   (spr_data),
`ifdef PIXEL_MIXER_PRIO_EN
        .spr_behind (spr_behind),
`endif
        .lb_addr    (lb_addr),
        .lb_data    (lb_data),
        .lb_wren    (lb_wren),
        .done       (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Engine line buffers: one-cycle registered read on the shared address.
    always @(posedge clk) begin
        bg_data  <= bg_mem[pixel_addr];
        fg_data  <= fg_mem[pixel_addr];
        spr_data <= spr_mem[pixel_addr];
`ifdef PIXEL_MIXER_PRIO_EN
        spr_behind <= beh_mem[pixel_addr];
`endif
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    endtask

    function automatic logic [7:0] ref_pix(input logic [7:0] b, input logic [7:0] f,
                                           input logic [7:0] s, input logic behind);
        int sc = int'(s) % 16;
        int fc = int'(f) % 16;
        int bc = int'(b) % 16;
        bit use_behind = 1'b0;
`ifdef PIXEL_MIXER_PRIO_EN
        use_behind = behind;
`endif
        if (sc != 0 && !(use_behind && fc != 0)) return s;
        if (fc != 0) return f;
        if (bc != 0) return b;
        return 8'h00;
    endfunction

    // Monitor: every scanline write is popped against the scoreboard.
    always @(negedge clk) begin
        if (rst_n && lb_wren) begin
            write_cnt++;
            if (first_w < 0) first_w = cyc;
            last_w = cyc;
            if (int'(lb_addr) < N) lb_mem[lb_addr] = lb_data;
            if (exp_q.size() == 0) begin
                check("unexpected_write", 1, 0);
            end else begin
                wr_t e;
                e = exp_q.pop_front();
                check("wr_addr", int'(lb_addr), e.addr);
                check("wr_data", int'(lb_data), int'(e.pix));
            end
        end
    end

    function automatic logic [7:0] rand_pix(input bit transparent);
        logic [7:0] v;
        v = 8'($urandom_range(0, 255));
        if (transparent || $urandom_range(0, 1) == 1) v[3:0] = 4'h0;
        return v;
    endfunction

    task automatic fill_random(input bit transparent);
        for (int i = 0; i < N; i++) begin
            bg_mem[i]  = rand_pix(transparent);
            fg_mem[i]  = rand_pix(transparent);
            spr_mem[i] = rand_pix(transparent);
            beh_mem[i] = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic set_dones(input logic v);
        bg_done  = v;
        fg_done  = v;
        spr_done = v;
    endtask

    task automatic load_expected();
        for (int i = 0; i < N; i++) begin
            wr_t e;
            e.addr = i;
            e.pix  = ref_pix(bg_mem[i], fg_mem[i], spr_mem[i], beh_mem[i]);
            exp_q.push_back(e);
        end
    endtask

    // Arms a line, then verifies the 320-write window and the done cycle relative to cycle 0.
    task automatic applyStimulus(input bit hold);
        int a;
        int n;
        int done_n;
        write_cnt = 0;
        first_w   = -1;
        last_w    = -1;
        done_n    = -1;
        load_expected();
        @(negedge clk);
        set_dones(1'b1);
        @(negedge clk);
        a = cyc;
        check("arm_addr0", int'(pixel_addr), 0);
        if (!hold) set_dones(1'b0);
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            n = cyc - a;
            if (n == 200) check("mix_addr200", int'(pixel_addr), 200);
            if (done) begin
                done_n = n;
                break;
            end
        end
        check("done_cycle", done_n, 322);
        check("write_count", write_cnt, N);
        check("first_write_cycle", first_w - a, 2);
        check("last_write_cycle", last_w - a, 321);
        check("scoreboard_empty", exp_q.size(), 0);
        exp_q.delete();
    endtask

    task automatic checkOutput();
        check("done_high", int'(done), 1);
        @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        check("done_drop", int'(done), 0);
    endtask

    initial begin
        int a;
        rst_n = 1'b0;
        swap  = 1'b0;
        set_dones(1'b0);
        for (int i = 0; i < N; i++) begin
            bg_mem[i] = 8'h00; fg_mem[i] = 8'h00; spr_mem[i] = 8'h00; beh_mem[i] = 1'b0; lb_mem[i] = 8'h00;
        end
        repeat (3) @(negedge clk);
        check("rst_pixel_addr", int'(pixel_addr), 0);
        check("rst_lb_addr", int'(lb_addr), 0);
        check("rst_lb_data", int'(lb_data), 0);
        check("rst_lb_wren", int'(lb_wren), 0);
        check("rst_done", int'(done), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        $display("[TB] constant layers");
        for (int i = 0; i < N; i++) begin
            bg_mem[i] = 8'h12; fg_mem[i] = 8'h30; spr_mem[i] = 8'h00;
        end
        applyStimulus(1'b0);
        check("const_lb0", int'(lb_mem[0]), 8'h12);
        check("const_lb319", int'(lb_mem[319]), 8'h12);
        checkOutput();

        $display("[TB] per-address priority");
        for (int i = 0; i < N; i++) begin
            bg_mem[i] = 8'h01; fg_mem[i] = 8'h00; spr_mem[i] = 8'h00;
        end
        spr_mem[100] = 8'h45;
        fg_mem[100]  = 8'h67;
        fg_mem[101]  = 8'h67;
        applyStimulus(1'b0);
        check("lb100", int'(lb_mem[100]), 8'h45);
        check("lb101", int'(lb_mem[101]), 8'h67);
        check("lb102", int'(lb_mem[102]), 8'h01);
        checkOutput();

        $display("[TB] all transparent");
        fill_random(1'b1);
        applyStimulus(1'b0);
        checkOutput();

        $display("[TB] random lines");
        for (int r = 0; r < 2; r++) begin
            fill_random(1'b0);
            applyStimulus(1'b0);
            checkOutput();
        end

        $display("[TB] arm and swap together");
        write_cnt = 0;
        @(negedge clk);
        set_dones(1'b1);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        repeat (20) @(negedge clk);
        check("armswap_no_writes", write_cnt, 0);
        check("armswap_addr_held", int'(pixel_addr), 319);
        check("armswap_done", int'(done), 0);
        set_dones(1'b0);
        @(negedge clk);

        $display("[TB] abort mid-line");
        fill_random(1'b0);
        write_cnt = 0;
        first_w   = -1;
        last_w    = -1;
        load_expected();
        @(negedge clk);
        set_dones(1'b1);
        @(negedge clk);
        a = cyc;
        for (int k = 0; k < 200 && (cyc - a) < 150; k++) @(negedge clk);
        swap = 1'b1;
        @(negedge clk);
        swap = 1'b0;
        repeat (30) @(negedge clk);
        check("abort_last_write", int'(last_w - a <= 151), 1);
        check("abort_write_count", int'(write_cnt >= 149 && write_cnt <= 150), 1);
        check("abort_addr_held", int'(pixel_addr), 150);
        check("abort_done", int'(done), 0);
        exp_q.delete();
        set_dones(1'b0);
        @(negedge clk);
        fill_random(1'b0);
        applyStimulus(1'b0);
        checkOutput();

        $display("[TB] swap in DONE with inputs held");
        fill_random(1'b0);
        applyStimulus(1'b1);
        checkOutput();
        repeat (20) @(negedge clk);
        check("held_no_rearm", write_cnt, N);
        check("held_addr", int'(pixel_addr), 319);
        check("held_done", int'(done), 0);
        set_dones(1'b0);
        @(negedge clk);
        fill_random(1'b0);
        applyStimulus(1'b0);
        checkOutput();

`ifdef PIXEL_MIXER_PRIO_EN
        $display("[TB] sprite behind priority");
        fill_random(1'b0);
        spr_mem[10] = 8'h45;
        fg_mem[10]  = 8'h67;
        beh_mem[10] = 1'b1;
        applyStimulus(1'b0);
        check("prio_behind_lb10", int'(lb_mem[10]), 8'h67);
        checkOutput();
        beh_mem[10] = 1'b0;
        applyStimulus(1'b0);
        check("prio_front_lb10", int'(lb_mem[10]), 8'h45);
        checkOutput();
`endif

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/pixel_mixer.md
# pixel_mixer

Consumes the per-line pixel buffers of the BG tile engine, FG tile engine and sprite engine once all three report done. Walks pixel addresses 0..319 over the shared engine read port, picks the top non-transparent pixel per position, and writes the 320-entry result into the scanline buffer that feeds the HDMI output. Raises `done` for ppu_logic when the line is complete, and holds it until the next buffer swap.

## Interface
- `LINE_PIXELS`, default 320: pixels per line and mix count.
- `PIX_W`, default 8: pixel width. [7:4] is the palette, [3:0] is the colour index. Colour index 0 means transparent.
- `clk` in 1: single clock for the block.
- `rst_n` in 1: reset, asynchronous, active-low.
- `swap` in 1: one-cycle buffer-swap pulse from ppu_logic.
- `bg_done`, `fg_done`, `spr_done` in 1 each: layer engines have finished their line buffers.
- `pixel_addr` out 9: shared read address to all three engine buffers.
- `bg_data`, `fg_data`, `spr_data` in 8 each: engine read data, valid 1 cycle after `pixel_addr`.
- `lb_addr` out 9: scanline buffer write address.
- `lb_data` out 8: scanline buffer write data.
- `lb_wren` out 1: scanline buffer write enable.
- `done` out 1: mix of the current line is complete.

## Operation
- States:
  - IDLE: waits for arm.
  - MIX: issues addresses.
  - DRAIN: flushes the pipeline.
  - DONE: holds `done`.
- Arm condition:
  - `all_done = bg_done & fg_done & spr_done` is registered.
  - The block arms only on the rising edge of `all_done`. A level that stays high after a swap therefore never re-triggers.
- IDLE→MIX on arm. Counter `cnt` clears to 0.
- MIX:
  - `pixel_addr = cnt`, and `cnt` increments each cycle.
  - At `cnt == LINE_PIXELS-1`, go to DRAIN.
- DRAIN lasts 2 cycles, then goes to DONE.
- DONE:
  - `done` is 1.
  - On `swap`, go to IDLE. `done` drops the next cycle.
- Selection, in fixed priority order:
  - spr if `spr_data[3:0] != 0`,
  - else fg if `fg_data[3:0] != 0`,
  - else bg if `bg_data[3:0] != 0`,
  - else backdrop `8'h00`.
- `swap` in MIX or DRAIN aborts the line:
  - next state is IDLE;
  - `lb_wren` is 0 from the next cycle;
  - in-flight pixels are discarded;
  - `done` stays 0.
- `swap` in IDLE has no effect.
- Arm and `swap` in the same cycle: `swap` wins and the state stays IDLE.
- `pixel_addr` holds its last value outside MIX. `lb_wren` is 0 outside write cycles.
- Counter width is 9 bits. `cnt` never exceeds `LINE_PIXELS-1`; there is no wrap.

## Timing
- Reset values: state IDLE, `pixel_addr` 0, `lb_addr` 0, `lb_data` 0, `lb_wren` 0, `done` 0, registered `all_done` 0.
- Cycle 0 is the first MIX cycle, with `pixel_addr = 0`.
- At cycle k (0..319), `pixel_addr = k`. Data for pixel k arrives at cycle k+1.
- `lb_wren`, `lb_addr = k` and `lb_data` are registered and visible at cycle k+2.
- The first write is at cycle 2. The last write (addr 319) is at cycle 321.
- `done` first reads 1 at cycle 322.
- Exactly 320 writes per completed line: one per cycle, in ascending address order, with no gaps.
- Arm latency: 1 cycle from all three done inputs sampled high to `pixel_addr = 0`. This comes from the edge register.

## Configuration
- `PIXEL_MIXER_PRIO_EN`, when defined:
  - Adds input `spr_behind` (1 bit), aligned with `spr_data`.
  - When `spr_behind` = 1 and the FG pixel is opaque, FG wins over the sprite.
  - BG ordering is unchanged.
- Without the macro: the port is absent and the fixed order is SPR > FG > BG.

## Structure
- Shared package `ppu_pkg` holds:
  - `LINE_PIXELS`;
  - `PIX_W`;
  - backdrop constant `PIX_BACKDROP = 8'h00`;
  - `function is_opaque(pix)`;
  - enum `mixer_state_t {IDLE, MIX, DRAIN, DONE}`.
- Sub-module `pixel_mixer_select`:
  - combinational three-layer priority select;
  - carries the `spr_behind` input only under `PIXEL_MIXER_PRIO_EN`.
- Address/data delay registers (2 stages for the address, 1 for the data) stay in `pixel_mixer`.

## Test plan
- Reset, then pulse all done inputs high with BG=`8'h12`, FG=`8'h30`, SPR=`8'h00` everywhere:
  - 320 writes of `8'h12`;
  - first write at cycle 2, last write at cycle 321, `done`=1 at cycle 322.
- Per-address data with SPR=`8'h45` only at addr 100, FG=`8'h67` at addrs 100–101, BG=`8'h01` elsewhere:
  - lb[100]=`8'h45`, lb[101]=`8'h67`, lb[102]=`8'h01`.
- All layers transparent (`x0` colour index): every write is `8'h00`.
- `swap` at cycle 150 of MIX:
  - no `lb_wren` after cycle 151;
  - state IDLE and `done` stays 0;
  - `all_done` held high does not re-arm; a fresh rising edge re-arms and completes 320 writes.
- In DONE, `swap` with done inputs still high:
  - `done` falls next cycle and no new MIX starts;
  - dropping then raising the done inputs starts a new line.
- With `PIXEL_MIXER_PRIO_EN`, `spr_behind`=1, SPR=`8'h45`, FG=`8'h67` at addr 10: lb[10]=`8'h67`. With `spr_behind`=0: lb[10]=`8'h45`.
